// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM stage: load/store types, dump FSM states and default depth.
package mem_access_stage_pkg;

  localparam int DEF_MEM_ADDR_BITS = 5;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LBU = 3'b001;
  localparam logic [2:0] LD_LH  = 3'b010;
  localparam logic [2:0] LD_LHU = 3'b011;
  localparam logic [2:0] LD_LW  = 3'b100;

  localparam logic [1:0] WR_SB = 2'b00;
  localparam logic [1:0] WR_SH = 2'b01;
  localparam logic [1:0] WR_SW = 2'b10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DUMP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/mem_load_extender.sv
// Selects the byte/halfword lane of a memory word and sign- or zero-extends it.
module mem_load_extender
  import mem_access_stage_pkg::*;
#(
  parameter int BUS_SIZE = 32
) (
  input  logic [BUS_SIZE-1:0] word,
  input  logic [1:0]          lane,
  input  logic [2:0]          rd_src,
  output logic [BUS_SIZE-1:0] data
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  assign sel_b = word[8*lane +: 8];
  // Half lane comes from lane[1] only, which also realigns odd halfword addresses.
  assign sel_h = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    case (rd_src)
      LD_LB:   data = {{(BUS_SIZE-8){sel_b[7]}}, sel_b};
      LD_LBU:  data = {{(BUS_SIZE-8){1'b0}}, sel_b};
      LD_LH:   data = {{(BUS_SIZE-16){sel_h[15]}}, sel_h};
      LD_LHU:  data = {{(BUS_SIZE-16){1'b0}}, sel_h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: data memory with sub-word loads/stores and a debug dump stream.
// Optional macro MEM_ALIGN_CHECK_EN flags misaligned accesses, drops such stores and zeroes such loads.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int BUS_SIZE      = 32,
  parameter int MEM_ADDR_BITS = DEF_MEM_ADDR_BITS,
  parameter int REG_ADDR_SIZE = 5
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic [2:0]               i_mem_rd_src,
  input  logic [1:0]               i_mem_wr_src,
  input  logic                     i_mem_write,
  input  logic                     i_wb,
  input  logic                     i_mem_to_reg,
  input  logic [BUS_SIZE-1:0]      i_bus_b,
  input  logic [BUS_SIZE-1:0]      i_alu_result,
  input  logic [REG_ADDR_SIZE-1:0] i_addr_wr,
  output logic [BUS_SIZE-1:0]      o_mem_rd_data,
  output logic [BUS_SIZE-1:0]      o_alu_result,
  output logic [REG_ADDR_SIZE-1:0] o_addr_wr,
  output logic                     o_wb,
  output logic                     o_mem_to_reg,
  output logic                     o_misaligned,
  input  logic                     i_dbg_dump_start,
  input  logic                     i_dbg_ready,
  output logic                     o_dbg_valid,
  output logic [MEM_ADDR_BITS-1:0] o_dbg_addr,
  output logic [BUS_SIZE-1:0]      o_dbg_data,
  output logic                     o_dbg_done,
  output logic [1:0]               o_dbg_state
);

  localparam int DEPTH = 1 << MEM_ADDR_BITS;
  localparam logic [MEM_ADDR_BITS-1:0] LAST_IDX = MEM_ADDR_BITS'(DEPTH - 1);

  logic [BUS_SIZE-1:0]      mem [DEPTH];
  logic [MEM_ADDR_BITS-1:0] w_idx;
  logic [1:0]               lane;
  logic [3:0]               be;
  logic [BUS_SIZE-1:0]      wdata;
  logic [BUS_SIZE-1:0]      ld_data;
  logic                     st_bad;
  logic                     ld_bad;
  logic                     st_en;
  logic                     unused_addr_hi;

  assign w_idx = i_alu_result[MEM_ADDR_BITS+1:2];
  assign lane  = i_alu_result[1:0];
  assign unused_addr_hi = ^i_alu_result[BUS_SIZE-1:MEM_ADDR_BITS+2];

  assign o_alu_result = i_alu_result;
  assign o_addr_wr    = i_addr_wr;
  assign o_wb         = i_wb;
  assign o_mem_to_reg = i_mem_to_reg;

  assign st_bad = ((i_mem_wr_src == WR_SH) & lane[0]) | (i_mem_wr_src[1] & (lane != 2'b00));
  assign ld_bad = ((i_mem_rd_src[2:1] == 2'b01) & lane[0]) | (i_mem_rd_src[2] & (lane != 2'b00));

  // Store lanes: sub-word data is replicated across the word so the byte enables pick it out.
  always_comb begin
    be    = 4'b1111;
    wdata = i_bus_b;
    case (i_mem_wr_src)
      WR_SB: begin
        be    = 4'b0001 << lane;
        wdata = {4{i_bus_b[7:0]}};
      end
      WR_SH: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{i_bus_b[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  mem_load_extender #(.BUS_SIZE(BUS_SIZE)) u_ext (
    .word   (mem[w_idx]),
    .lane   (lane),
    .rd_src (i_mem_rd_src),
    .data   (ld_data)
  );

`ifdef MEM_ALIGN_CHECK_EN
  assign o_misaligned  = (i_mem_write & st_bad) | (i_mem_to_reg & ld_bad);
  assign st_en         = i_enable & i_mem_write & ~st_bad;
  assign o_mem_rd_data = (i_mem_to_reg & ld_bad) ? '0 : ld_data;
`else
  logic unused_bad;
  assign unused_bad    = st_bad ^ ld_bad;
  assign o_misaligned  = 1'b0;
  assign st_en         = i_enable & i_mem_write;
  assign o_mem_rd_data = ld_data;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (st_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Dump handshake: a word moves on any rising edge where o_dbg_valid & i_dbg_ready;
  // while valid is high and ready is low, o_dbg_addr stays put and o_dbg_data tracks mem[addr].
  logic [1:0]               state, state_nxt;
  logic [MEM_ADDR_BITS-1:0] cnt, cnt_nxt;
  logic                     xfer;

  assign o_dbg_valid = (state == S_DUMP);
  assign o_dbg_done  = (state == S_DONE);
  assign o_dbg_addr  = cnt;
  assign o_dbg_data  = mem[cnt];
  assign o_dbg_state = state;
  assign xfer        = o_dbg_valid & i_dbg_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (i_dbg_dump_start) begin
          state_nxt = S_DUMP;
          cnt_nxt   = '0;
        end
      end
      S_DUMP: begin
        if (xfer) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST_IDX) state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads/stores, enable gating, dump stream, reset abort, alignment.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_enable = 1'b1;
  logic [2:0]  i_mem_rd_src = LD_LW;
  logic [1:0]  i_mem_wr_src = WR_SW;
  logic        i_mem_write = 1'b0;
  logic        i_wb = 1'b0;
  logic        i_mem_to_reg = 1'b0;
  logic [31:0] i_bus_b = '0;
  logic [31:0] i_alu_result = '0;
  logic [4:0]  i_addr_wr = '0;
  logic [31:0] o_mem_rd_data, o_alu_result, o_dbg_data;
  logic [4:0]  o_addr_wr, o_dbg_addr;
  logic        o_wb, o_mem_to_reg, o_misaligned, o_dbg_valid, o_dbg_done;
  logic        i_dbg_dump_start = 1'b0;
  logic        i_dbg_ready = 1'b0;
  logic [1:0]  o_dbg_state;

  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  mem_access_stage dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable),
    .i_mem_rd_src(i_mem_rd_src), .i_mem_wr_src(i_mem_wr_src), .i_mem_write(i_mem_write),
    .i_wb(i_wb), .i_mem_to_reg(i_mem_to_reg), .i_bus_b(i_bus_b),
    .i_alu_result(i_alu_result), .i_addr_wr(i_addr_wr),
    .o_mem_rd_data(o_mem_rd_data), .o_alu_result(o_alu_result), .o_addr_wr(o_addr_wr),
    .o_wb(o_wb), .o_mem_to_reg(o_mem_to_reg), .o_misaligned(o_misaligned),
    .i_dbg_dump_start(i_dbg_dump_start), .i_dbg_ready(i_dbg_ready),
    .o_dbg_valid(o_dbg_valid), .o_dbg_addr(o_dbg_addr), .o_dbg_data(o_dbg_data),
    .o_dbg_done(o_dbg_done), .o_dbg_state(o_dbg_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data,
                       input logic [1:0] src, input logic en);
    @(negedge i_clk);
    i_alu_result = addr;
    i_bus_b      = data;
    i_mem_wr_src = src;
    i_enable     = en;
    i_mem_write  = 1'b1;
    i_mem_to_reg = 1'b0;
    @(negedge i_clk);
    i_mem_write  = 1'b0;
    i_enable     = 1'b1;
  endtask

  task automatic load(input logic [31:0] addr, input logic [2:0] src);
    i_alu_result = addr;
    i_mem_rd_src = src;
    i_mem_to_reg = 1'b1;
    #1;
  endtask

  initial begin
    int n_xfer;
    int n_done;
    int idx;
    logic ready_t;

    // Reset and empty memory
    #12;
    check("rst_valid", 32'(o_dbg_valid), 32'd0);
    check("rst_done", 32'(o_dbg_done), 32'd0);
    check("rst_addr", 32'(o_dbg_addr), 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'(S_IDLE));
    @(negedge i_clk);
    i_reset = 1'b0;
    for (int a = 0; a <= 124; a += 4) begin
      load(32'(a), LD_LW);
      check($sformatf("lw_zero_%0d", a), o_mem_rd_data, 32'd0);
    end

    // Pass-throughs
    i_wb = 1'b1; i_addr_wr = 5'd19; i_alu_result = 32'hDEAD_0123; #1;
    check("pt_alu", o_alu_result, 32'hDEAD_0123);
    check("pt_addr_wr", 32'(o_addr_wr), 32'd19);
    check("pt_wb_mtr", {30'd0, o_wb, o_mem_to_reg}, 32'd3);

    // Sub-word loads with extension
    store(32'h10, 32'h8899AABB, WR_SW, 1'b1);
    load(32'h11, LD_LB);  check("lb_11", o_mem_rd_data, 32'hFFFFFFAA);
    load(32'h11, LD_LBU); check("lbu_11", o_mem_rd_data, 32'h000000AA);
    load(32'h12, LD_LH);  check("lh_12", o_mem_rd_data, 32'hFFFF8899);
    load(32'h10, LD_LHU); check("lhu_10", o_mem_rd_data, 32'h0000AABB);
    load(32'h10, LD_LB);  check("lb_10", o_mem_rd_data, 32'hFFFFFFBB);
    load(32'h13, LD_LBU); check("lbu_13", o_mem_rd_data, 32'h00000088);
    load(32'h10, 3'b111); check("lw_alias", o_mem_rd_data, 32'h8899AABB);
    load(32'h90, LD_LW);  check("lw_wrap", o_mem_rd_data, 32'h8899AABB);

    // Sub-word stores preserve neighbouring bytes; enable gates the store
    store(32'h20, 32'h11223344, WR_SW, 1'b1);
    store(32'h23, 32'h000000EE, WR_SB, 1'b1);
    load(32'h20, LD_LW); check("sb_23", o_mem_rd_data, 32'hEE223344);
    store(32'h20, 32'h00005566, WR_SH, 1'b1);
    load(32'h20, LD_LW); check("sh_20", o_mem_rd_data, 32'hEE225566);
    store(32'h20, 32'hDEADBEEF, WR_SW, 1'b0);
    load(32'h20, LD_LW); check("en0_sw", o_mem_rd_data, 32'hEE225566);
    store(32'h22, 32'h0000CDEF, WR_SH, 1'b1);
    load(32'h20, LD_LW); check("sh_22", o_mem_rd_data, 32'hCDEF5566);

    // Read-before-write on the same word
    @(negedge i_clk);
    i_alu_result = 32'h24; i_bus_b = 32'hCAFEF00D; i_mem_wr_src = WR_SW;
    i_mem_rd_src = LD_LW; i_mem_write = 1'b1; #1;
    check("rbw_old", o_mem_rd_data, 32'd0);
    @(negedge i_clk);
    i_mem_write = 1'b0; #1;
    check("rbw_new", o_mem_rd_data, 32'hCAFEF00D);

    // Dump: word i = i, ready toggling, one ignored start mid-dump
    for (int i = 0; i < 32; i++) begin
      store(32'(i * 4), 32'(i), WR_SW, 1'b1);
      exp_q.push_back(32'(i));
    end
    @(negedge i_clk);
    i_dbg_dump_start = 1'b1;
    @(negedge i_clk);
    i_dbg_dump_start = 1'b0;
    n_xfer = 0; n_done = 0; idx = 0; ready_t = 1'b0;
    for (int cyc = 0; cyc < 90; cyc++) begin
      i_dbg_ready = ready_t;
      ready_t = ~ready_t;
      i_dbg_dump_start = (cyc == 20);
      #1;
      if (o_dbg_done) n_done++;
      if (o_dbg_valid && i_dbg_ready) begin
        check($sformatf("dump_addr_%0d", idx), 32'(o_dbg_addr), 32'(idx));
        if (exp_q.size() > 0) check($sformatf("dump_data_%0d", idx), o_dbg_data, exp_q.pop_front());
        else check("dump_extra", o_dbg_data, 32'hFFFF_FFFF);
        idx++;
        n_xfer++;
      end
      @(negedge i_clk);
    end
    i_dbg_dump_start = 1'b0;
    check("dump_count", 32'(n_xfer), 32'd32);
    check("dump_done_pulses", 32'(n_done), 32'd1);
    check("dump_q_empty", 32'(exp_q.size()), 32'd0);
    check("dump_idle_valid", 32'(o_dbg_valid), 32'd0);

    // Reset at transfer 10 aborts the dump
    i_dbg_ready = 1'b1;
    i_dbg_dump_start = 1'b1;
    @(negedge i_clk);
    i_dbg_dump_start = 1'b0;
    n_xfer = 0;
    for (int cyc = 0; cyc < 60 && n_xfer < 10; cyc++) begin
      #1;
      if (o_dbg_valid && i_dbg_ready) n_xfer++;
      @(negedge i_clk);
    end
    check("abort_reached", 32'(n_xfer), 32'd10);
    i_reset = 1'b1; #1;
    check("abort_valid", 32'(o_dbg_valid), 32'd0);
    check("abort_addr", 32'(o_dbg_addr), 32'd0);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    n_done = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (o_dbg_done || o_dbg_valid) n_done++;
      @(negedge i_clk);
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    load(32'h14, LD_LW); check("abort_mem_clr", o_mem_rd_data, 32'd0);

    // Alignment handling
    store(32'h20, 32'hA5A5A5A5, WR_SW, 1'b1);
    @(negedge i_clk);
    i_alu_result = 32'h21; i_bus_b = 32'h12345678; i_mem_wr_src = WR_SW;
    i_mem_to_reg = 1'b0; i_mem_write = 1'b1; #1;
`ifdef MEM_ALIGN_CHECK_EN
    check("mis_flag", 32'(o_misaligned), 32'd1);
    @(negedge i_clk);
    i_mem_write = 1'b0;
    load(32'h20, LD_LW); check("mis_sw_drop", o_mem_rd_data, 32'hA5A5A5A5);
    load(32'h22, LD_LW); check("mis_lw_zero", o_mem_rd_data, 32'd0);
    check("mis_ld_flag", 32'(o_misaligned), 32'd1);
    load(32'h21, LD_LH); check("mis_lh_zero", o_mem_rd_data, 32'd0);
`else
    check("mis_flag", 32'(o_misaligned), 32'd0);
    @(negedge i_clk);
    i_mem_write = 1'b0;
    load(32'h20, LD_LW); check("mis_sw_force", o_mem_rd_data, 32'h12345678);
    load(32'h22, LD_LW); check("mis_lw_force", o_mem_rd_data, 32'h12345678);
    check("mis_ld_flag", 32'(o_misaligned), 32'd0);
    load(32'h21, LD_LH); check("mis_lh_force", o_mem_rd_data, 32'h00005678);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Holds the data memory and performs byte, halfword and word loads and stores, with load extension.
- Passes write-back control and the ALU result straight through to MEM/WB.
- Provides a debug dump port: an FSM streams the full memory contents to the debug unit over a valid/ready handshake.

Parameters:
- BUS_SIZE, 32, datapath width in bits.
- MEM_ADDR_BITS, 5, word-index width. Depth is 2^MEM_ADDR_BITS words.
- REG_ADDR_SIZE, 5, width of the destination register address.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset
- i_enable  in  1  pipeline step enable
- i_mem_rd_src  in  3  load type
- i_mem_wr_src  in  2  store type
- i_mem_write  in  1  store request
- i_wb  in  1  register write-back control
- i_mem_to_reg  in  1  write-back source select
- i_bus_b  in  BUS_SIZE  store data
- i_alu_result  in  BUS_SIZE  byte address / ALU result
- i_addr_wr  in  REG_ADDR_SIZE  destination register
- o_mem_rd_data  out  BUS_SIZE  extended load data
- o_alu_result  out  BUS_SIZE  pass-through
- o_addr_wr  out  REG_ADDR_SIZE  pass-through
- o_wb  out  1  pass-through
- o_mem_to_reg  out  1  pass-through
- o_misaligned  out  1  misaligned access this cycle
- i_dbg_dump_start  in  1  start-dump pulse
- i_dbg_ready  in  1  debug consumer ready
- o_dbg_valid  out  1  dump word valid
- o_dbg_addr  out  MEM_ADDR_BITS  word index of dump word
- o_dbg_data  out  BUS_SIZE  dump word
- o_dbg_done  out  1  one-cycle end-of-dump pulse

Behaviour:
- Reset: asynchronous, active-high, on i_reset; clock is i_clk. Reset clears every memory word to 0, puts the FSM in IDLE and clears the dump counter. Resulting outputs: o_dbg_valid=0, o_dbg_done=0, o_dbg_addr=0. Pass-throughs and o_mem_rd_data are combinational and follow their inputs / memory.
- Addressing:
  - Word index = i_alu_result[MEM_ADDR_BITS+1:2]. Byte lane = i_alu_result[1:0].
  - Upper address bits are ignored, so addresses wrap modulo memory size. Layout is little-endian.
- Load (combinational, zero latency, so MEM/WB captures it on the same edge):
  - i_mem_rd_src 000 = LB (sign-extend byte).
  - 001 = LBU (zero-extend byte).
  - 010 = LH (sign-extend half; lane = addr[1]).
  - 011 = LHU (zero-extend half).
  - 100 = LW.
  - 101-111 = LW.
- Store (synchronous, posedge i_clk):
  - Occurs only when i_enable & i_mem_write.
  - i_mem_wr_src 00 = SB: only the selected byte lane is written from i_bus_b[7:0].
  - 01 = SH: the lane pair selected by addr[1] is written from i_bus_b[15:0].
  - 10/11 = SW: the full word is written.
  - Other bytes of the word are preserved.
- Read during write, same address: o_mem_rd_data shows the old contents until the edge (read-before-write).
- i_enable=0 means no store. Pass-throughs remain combinational.
- Dump FSM, states IDLE, DUMP, DONE:
  - IDLE: o_dbg_valid=0. i_dbg_dump_start → DUMP with counter=0. Start pulses in DUMP or DONE are ignored.
  - DUMP: o_dbg_valid=1, o_dbg_addr=counter, o_dbg_data=mem[counter] (combinational). On valid&ready, counter increments. On the handshake with counter = depth-1 → DONE. Without ready, addr and data hold stable unless a pipeline store hits that word.
  - DONE: o_dbg_done=1 for exactly one cycle → IDLE.
  - The dump reads through a second read port and runs concurrently with pipeline accesses. A store and a handshake on the same word in the same cycle transfer the old value.
- Reset mid-dump aborts the dump immediately. No done pulse is issued.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - o_misaligned = (i_mem_write | load active) & (half with addr[0]=1, or word with addr[1:0]≠0).
  - A misaligned store is suppressed. A misaligned load returns 0.
  - "Load active" = i_mem_to_reg.
- Undefined:
  - o_misaligned tied 0.
  - Halfword accesses force addr[0]=0. Word accesses force addr[1:0]=0.

Decomposition:
- Shared package/header holds:
  - Load encodings LB, LBU, LH, LHU, LW.
  - Store encodings SB, SH, SW.
  - FSM state encodings.
  - Default MEM_ADDR_BITS.
- One natural sub-module, mem_load_extender: combinational lane select plus sign/zero extension.

Test Plan:
- Reset, then LW at addresses 0..124 → all reads 0. After reset, o_dbg_valid=0 and o_dbg_done=0.
- SW 0x8899AABB @0x10, then LB @0x11 → 0xFFFFFFAA. LBU @0x11 → 0x000000AA. LH @0x12 → 0xFFFF8899. LHU @0x10 → 0x0000AABB.
- SW 0x11223344 @0x20, SB 0xEE @0x23, SH 0x5566 @0x20 → LW @0x20 = 0xEE225566. Repeat the store with i_enable=0 → no change.
- Write word i = i at every word, pulse i_dbg_dump_start with i_dbg_ready toggling 1/0 → 32 transfers in order 0..31 with data=i, then a single o_dbg_done pulse. Assert i_reset at transfer 10 → valid drops and no done pulse.
- MEM_ALIGN_CHECK_EN defined: SW @0x21 → o_misaligned=1 and word 0x20 unchanged. Undefined: same SW writes word 0x20 and o_misaligned=0.
